// File: rtl/jtag_tap_if.sv
// TAP pin bundle: TMS/TDI from the host, TDO/TDO-enable back to it.
interface jtag_tap_if;
  logic i_tms;
  logic i_tdi;
  logic o_tdo;
  logic o_tdoEn;

  modport master (output i_tms, output i_tdi, input  o_tdo, input  o_tdoEn);
  modport slave  (input  i_tms, input  i_tdi, output o_tdo, output o_tdoEn);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, IR/DR shift paths and TDO mux.
// Registered actions happen on the TCK edge that leaves the named state; TDO is combinational.
module jtag_tap_ctrl #(
  parameter int              REG_W        = 32,
  parameter logic [REG_W-1:0] IDCODE_INSTR = REG_W'(1),
  parameter logic [REG_W-1:0] USER_INSTR   = REG_W'(2),
  parameter logic [REG_W-1:0] BYPASS_INSTR = {REG_W{1'b1}}
) (
  input  logic             i_tclk,
  input  logic             i_trst_n,
  jtag_tap_if.slave        tap,
  input  logic [REG_W-1:0] i_dataReg,
  output logic [REG_W-1:0] o_shiftReg,
  output logic [REG_W-1:0] o_instrReg,
  output logic             o_stateIsUpdateDr,
  output logic             o_stateIsCaptureDr,
  output logic [3:0]       o_state
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF, S_RTI   = 4'hC,
    S_SELDR = 4'h7, S_CAPDR = 4'h6, S_SHDR = 4'h2, S_EX1DR = 4'h1,
    S_PAUDR = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
    S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA, S_EX1IR = 4'h9,
    S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REG_W-1:0] r_dr_shift;
  logic [REG_W-1:0] r_ir_shift;
  logic [REG_W-1:0] r_instr;
  logic             r_bypass;
  logic             w_dr_selected;

  always_ff @(posedge i_tclk) begin
    if (!i_trst_n) r_state <= S_TLR;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TLR:   w_state_nxt = tap.i_tms ? S_TLR   : S_RTI;
      S_RTI:   w_state_nxt = tap.i_tms ? S_SELDR : S_RTI;
      S_SELDR: w_state_nxt = tap.i_tms ? S_SELIR : S_CAPDR;
      S_CAPDR: w_state_nxt = tap.i_tms ? S_EX1DR : S_SHDR;
      S_SHDR:  w_state_nxt = tap.i_tms ? S_EX1DR : S_SHDR;
      S_EX1DR: w_state_nxt = tap.i_tms ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_state_nxt = tap.i_tms ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_state_nxt = tap.i_tms ? S_UPDDR : S_SHDR;
      S_UPDDR: w_state_nxt = tap.i_tms ? S_SELDR : S_RTI;
      S_SELIR: w_state_nxt = tap.i_tms ? S_TLR   : S_CAPIR;
      S_CAPIR: w_state_nxt = tap.i_tms ? S_EX1IR : S_SHIR;
      S_SHIR:  w_state_nxt = tap.i_tms ? S_EX1IR : S_SHIR;
      S_EX1IR: w_state_nxt = tap.i_tms ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_state_nxt = tap.i_tms ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_state_nxt = tap.i_tms ? S_UPDIR : S_SHIR;
      S_UPDIR: w_state_nxt = tap.i_tms ? S_SELDR : S_RTI;
      default: w_state_nxt = S_TLR;
    endcase
  end

  always_ff @(posedge i_tclk) begin
    if (!i_trst_n) begin
      r_dr_shift <= '0;
      r_ir_shift <= '0;
      r_instr    <= IDCODE_INSTR;
      r_bypass   <= 1'b0;
    end else begin
      case (r_state)
        S_CAPDR: begin
          r_dr_shift <= i_dataReg;
          r_bypass   <= 1'b0;
        end
        S_SHDR: begin
          r_dr_shift <= {tap.i_tdi, r_dr_shift[REG_W-1:1]};
          r_bypass   <= tap.i_tdi;
        end
        S_CAPIR: r_ir_shift <= REG_W'(1);
        S_SHIR:  r_ir_shift <= {tap.i_tdi, r_ir_shift[REG_W-1:1]};
        S_UPDIR: r_instr    <= r_ir_shift;
        default: ;
      endcase
      // Entering Test-Logic-Reset by TMS restores the power-up instruction.
      if (w_state_nxt == S_TLR) r_instr <= IDCODE_INSTR;
    end
  end

  // Anything other than a recognised DR-backed instruction routes TDO through bypass.
  assign w_dr_selected = (r_instr == IDCODE_INSTR) || (r_instr == USER_INSTR);

  always_comb begin
    tap.o_tdo = 1'b0;
    if (r_state == S_SHIR)
      tap.o_tdo = r_ir_shift[0];
    else if (r_state == S_SHDR)
      tap.o_tdo = w_dr_selected ? r_dr_shift[0] : r_bypass;
  end

  assign tap.o_tdoEn        = (r_state == S_SHDR) || (r_state == S_SHIR);
  assign o_shiftReg         = r_dr_shift;
  assign o_instrReg         = r_instr;
  assign o_stateIsUpdateDr  = (r_state == S_UPDDR);
  assign o_stateIsCaptureDr = (r_state == S_CAPDR);
  assign o_state            = r_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE read, IR load, USER write, bypass, pause/resume, FSM coverage.
module tb_jtag_tap_ctrl;
  localparam logic [31:0] IDCODE  = 32'h0000_0001;
  localparam logic [31:0] USER    = 32'h0000_0002;
  localparam logic [31:0] BYPASS  = 32'hFFFF_FFFF;
  localparam logic [31:0] ID_CODE = 32'h1234_5A6F;

  logic        tclk = 1'b0;
  logic        trst_n;
  logic [31:0] data_reg;
  logic [31:0] shift_reg;
  logic [31:0] instr_reg;
  logic        upd_dr;
  logic        cap_dr;
  logic [3:0]  state;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] cov_st  [44];
  bit         cov_tms [44];

  jtag_tap_if tap_if ();

  jtag_tap_ctrl #(.REG_W(32)) dut (
    .i_tclk             (tclk),
    .i_trst_n           (trst_n),
    .tap                (tap_if),
    .i_dataReg          (data_reg),
    .o_shiftReg         (shift_reg),
    .o_instrReg         (instr_reg),
    .o_stateIsUpdateDr  (upd_dr),
    .o_stateIsCaptureDr (cap_dr),
    .o_state            (state)
  );

  initial forever #5 tclk = ~tclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tclk);
    #1;
  endtask

  task automatic tms_step(input bit t);
    tap_if.i_tms = t;
    step();
  endtask

  // Shift n bits LSB first; TMS goes high on the last bit when exit_last is set.
  task automatic shift_bits(input logic [31:0] din, input int n, input bit exit_last,
                            output logic [31:0] dout, output int en_cnt, output int cap_cnt);
    dout = '0;
    en_cnt = 0;
    cap_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tap_if.i_tdi = din[i];
      tap_if.i_tms = exit_last && (i == n - 1);
      dout[i] = tap_if.o_tdo;
      en_cnt += int'(tap_if.o_tdoEn);
      cap_cnt += int'(cap_dr);
      step();
    end
    tap_if.i_tdi = 1'b0;
  endtask

  // From RTI: load an instruction through the IR path and return to RTI.
  task automatic load_ir(input logic [31:0] instr, output logic [31:0] tdo_word);
    int en, cp;
    tms_step(1); tms_step(1); tms_step(0); tms_step(0);
    shift_bits(instr, 32, 1'b1, tdo_word, en, cp);
    tms_step(1);
    tms_step(0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp_pause;
    int en, cp, upd_cnt;

    cov_tms = '{1,0,0,1,0,1,0,0,1,0, 0,1,1,1,0,0,1,0,1,1, 0,1,1,0,1,0,0,1,0,0,
                1,1,1,1,0,0,1,0,1,1, 0,1,1,1};
    cov_st  = '{4'hF,4'hC,4'hC,4'h7,4'h6,4'h1,4'h3,4'h3,4'h0,4'h2,
                4'h2,4'h1,4'h5,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,
                4'hC,4'h7,4'h4,4'hE,4'h9,4'hB,4'hB,4'h8,4'hA,4'hA,
                4'h9,4'hD,4'h7,4'h4,4'hE,4'hA,4'h9,4'hB,4'h8,4'hD,
                4'hC,4'h7,4'h4,4'hF};

    trst_n = 1'b0; tap_if.i_tms = 1'b1; tap_if.i_tdi = 1'b0; data_reg = '0;
    step(); step();
    check("rst_state", 32'(state), 32'hF);
    check("rst_instr", instr_reg, IDCODE);
    check("rst_tdoen", 32'(tap_if.o_tdoEn), 32'h0);
    check("rst_shift", shift_reg, 32'h0);
    trst_n = 1'b1;

    // Reset taken from the middle of Shift-DR
    tms_step(0); tms_step(1); tms_step(0); tms_step(0);
    check("reach_shdr", 32'(state), 32'h2);
    trst_n = 1'b0; step(); trst_n = 1'b1;
    check("midshift_rst_state", 32'(state), 32'hF);
    check("midshift_rst_instr", instr_reg, IDCODE);
    check("midshift_rst_tdoen", 32'(tap_if.o_tdoEn), 32'h0);
    tms_step(0);
    for (int i = 0; i < 5; i++) tms_step(1);
    check("five_tms_tlr", 32'(state), 32'hF);

    // IDCODE read
    data_reg = ID_CODE;
    tms_step(0); tms_step(1); tms_step(0);
    check("id_capdr_flag", 32'(cap_dr), 32'h1);
    check("id_capdr_tdoen", 32'(tap_if.o_tdoEn), 32'h0);
    tms_step(0);
    shift_bits(32'h0, 32, 1'b1, word, en, cp);
    check("id_tdo_word", word, ID_CODE);
    check("id_tdoen_cycles", 32'(en), 32'd32);
    check("id_ex1_tdoen", 32'(tap_if.o_tdoEn), 32'h0);
    tms_step(1);
    check("id_upd_flag", 32'(upd_dr), 32'h1);
    tms_step(0);
    check("id_back_rti", 32'(state), 32'hC);

    // IR load of USER, then a USER data write
    load_ir(USER, word);
    check("ir_capture_tdo", word, 32'h0000_0001);
    check("ir_user_instr", instr_reg, USER);
    data_reg = '0;
    tms_step(1); tms_step(0); tms_step(0);
    shift_bits(32'hA5A5_1234, 32, 1'b1, word, en, cp);
    upd_cnt = int'(upd_dr);
    tms_step(1);
    check("user_upd_flag", 32'(upd_dr), 32'h1);
    check("user_shiftreg", shift_reg, 32'hA5A5_1234);
    upd_cnt += int'(upd_dr);
    tms_step(0);
    upd_cnt += int'(upd_dr);
    check("user_upd_pulses", 32'(upd_cnt), 32'd1);

    // BYPASS: one-cycle TDI->TDO with a captured 0 leading
    load_ir(BYPASS, word);
    check("byp_instr", instr_reg, BYPASS);
    tms_step(1); tms_step(0); tms_step(0);
    shift_bits(32'b1101, 4, 1'b1, word, en, cp);
    check("byp_tdo_bits", word, 32'b1010);
    tms_step(1); tms_step(0);

    // Unrecognised instruction behaves as bypass on TDO
    load_ir(32'h0000_0005, word);
    data_reg = 32'hFFFF_FFFF;
    tms_step(1); tms_step(0); tms_step(0);
    shift_bits(32'b01, 2, 1'b1, word, en, cp);
    check("unk_tdo_bits", word, 32'b10);
    tms_step(1); tms_step(0);

    // Pause and resume without recapture
    load_ir(USER, word);
    data_reg = 32'hCAFE_F00D;
    tms_step(1); tms_step(0); tms_step(0);
    shift_bits(32'h1357_9BDF, 8, 1'b1, word, en, cp);
    check("pause_first_tdo", word, 32'h0000_000D);
    exp_pause = (32'hCAFE_F00D >> 8) | (32'h0000_00DF << 24);
    tms_step(0);
    for (int i = 0; i < 10; i++) tms_step(0);
    check("pause_state", 32'(state), 32'h3);
    check("pause_hold", shift_reg, exp_pause);
    data_reg = 32'h0;
    tms_step(1);
    check("ex2_capdr_flag", 32'(cap_dr), 32'h0);
    tms_step(0);
    shift_bits(32'h1357_9BDF >> 8, 24, 1'b1, word, en, cp);
    check("resume_tdo", word, 32'h00CA_FEF0);
    check("resume_no_capture", 32'(cp), 32'h0);
    check("resume_final", shift_reg, 32'h1357_9BDF);
    tms_step(1); tms_step(0);

    // Full transition coverage from Test-Logic-Reset
    for (int i = 0; i < 5; i++) tms_step(1);
    for (int i = 0; i < 44; i++) begin
      tms_step(cov_tms[i]);
      check($sformatf("cov_%0d", i), 32'(state), 32'(cov_st[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that sequences the JTAG data-register datapath. Runs the 16-state TAP FSM from TMS and owns the instruction register, the IR shift path and the shared DR shift register. Drives capture, shift and update of the selected data register, and muxes TDO. Sits between the TAP pins and jtag_dataReg: supplies o_shiftReg, o_instrReg and o_stateIsUpdateDr, and consumes its o_dataReg.

Parameters:
REG_W, 32, width of the instruction register, the IR shift register and the DR shift register (matches jtag_pa REG_W).

Ports:
i_tclk  input  1  TCK; all logic on rising edge.
i_trst_n  input  1  synchronous, active-low reset.
i_tms  input  1  TMS.
i_tdi  input  1  TDI.
o_tdo  output  1  TDO.
o_tdoEn  output  1  TDO valid; high only in Shift-DR or Shift-IR.
i_dataReg  input  REG_W  selected DR value from jtag_dataReg, parallel-loaded at Capture-DR.
o_shiftReg  output  REG_W  DR shift register contents.
o_instrReg  output  REG_W  current instruction.
o_stateIsUpdateDr  output  1  high while the FSM is in Update-DR.
o_stateIsCaptureDr  output  1  high while in Capture-DR.
o_state  output  4  current FSM state encoding.

Behaviour:
- Reset: sampled only at posedge i_tclk with i_trst_n=0. Sets state=TLR, o_instrReg=IDCODE, DR shift=0, IR shift=0, bypass bit=0. Reset applied mid-shift discards the shift; o_instrReg is not updated.
- State encoding (o_state, hex):
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D
- Transitions, written TMS=0 / TMS=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - SelIR: CapIR / TLR.
  - CapX: ShX / Ex1X.
  - ShX: ShX / Ex1X.
  - Ex1X: PauX / UpdX.
  - PauX: PauX / Ex2X.
  - Ex2X: ShX / UpdX.
  - UpdX: RTI / SelDR.
- Five consecutive TMS=1 reach TLR from any state.
- Entering TLR by TMS also forces o_instrReg=IDCODE.
- Registered actions occur on the clock edge that leaves the named state:
  - CapDR: DR shift <= i_dataReg; bypass bit <= 0.
  - ShDR: DR shift <= {i_tdi, shift[REG_W-1:1]} (LSB first); bypass bit <= i_tdi.
  - CapIR: IR shift <= REG_W'(1) (standard 01 pattern).
  - ShIR: IR shift <= {i_tdi, irShift[REG_W-1:1]}.
  - UpdIR: o_instrReg <= IR shift.
  - All other states: DR shift, IR shift and o_instrReg hold.
- o_stateIsUpdateDr and o_stateIsCaptureDr are combinational decodes of state, high exactly one cycle per pass.
- TDO is combinational from the current state and registers:
  - ShIR: irShift[0].
  - ShDR with o_instrReg==BYPASS: bypass bit (1-cycle TDI->TDO path).
  - ShDR otherwise: DR shift[0].
  - Any other state: 0.
- Unknown or unsupported instructions are treated as BYPASS for the TDO path, per 1149.1.
- Pause states hold all shift contents indefinitely. Re-entering Shift via Ex2 resumes the shift without recapture.

Test Plan:
- Reset recovery: i_trst_n=0 for 1 cycle from state ShDR -> next cycle o_state=F, o_instrReg=IDCODE, o_tdoEn=0. Then from RTI drive TMS=1 for 5 cycles -> o_state=F.
- Default IDCODE read: reset, TMS 0,1,0,0 -> CapDR loads ID_CODE. Shift 32 bits -> o_tdo yields ID_CODE LSB first. o_tdoEn=1 only during the 32 ShDR cycles.
- IR load + USER write:
  - Shift USER code through IR; first 2 TDO bits are 1,0. Update-IR -> o_instrReg=USER.
  - Shift 0xA5A51234 through DR -> o_stateIsUpdateDr pulses exactly 1 cycle with o_shiftReg=0xA5A51234.
- BYPASS: o_instrReg=BYPASS, shift TDI pattern 1,0,1,1 -> TDO 0,1,0,1 (captured 0 first, then 1-cycle delay).
- Pause/resume: in ShDR after 8 bits, go to PauDR and hold 10 cycles -> o_shiftReg unchanged. Via Ex2 back to ShDR, the remaining 24 bits continue with no recapture and o_stateIsCaptureDr stays low.
- Transition coverage: drive TMS sequences hitting all 16 states and both TMS values in each -> o_state matches the encoding table on every cycle.
